// File: rtl/nf_10g_link_ctrl.sv
// nf_10g_link_ctrl
// Link bring-up and configuration controller for one 10G interface.
// It sequences the MAC and PCS/PMA resets, qualifies block lock before it
// declares the link up, and gates pipeline TX traffic. It counts link flaps
// and bring-up retries. It recovers on its own from lock loss, bring-up
// timeouts and SFP TX fault.
//
// Ports
//   core_clk, core_resetn        : clock, asynchronous active-low reset
//   cfg_enable                   : 0 holds the link in DISABLED
//   cfg_loopback                 : PMA loopback request
//   clear_stats                  : one-cycle pulse that zeroes both counters
//   pcspma_status[0]             : block lock (foreign domain, synchronised)
//   tx_resetdone, rx_resetdone   : transceiver reset done (synchronised)
//   tx_fault                     : SFP TX fault (synchronised)
//   mac_{tx,rx}_configuration_vector : bit0 reset, bit1 enable
//   pcs_pma_configuration_vector : bit0 loopback, bit15 PMA reset, bit111 PCS reset
//   link_up, tx_gate             : high only in UP
//   link_state                   : encoded state, one cycle behind the FSM
//   flap_count, retry_count      : saturating statistics counters
module nf_10g_link_ctrl #(
  parameter int C_DEBOUNCE_CYCLES = 1024,
  parameter int C_LOSS_TIMEOUT    = 65536,
  parameter int C_RESET_PULSE     = 16,
  parameter int C_CNT_WIDTH       = 32
) (
  input  logic                   core_clk,
  input  logic                   core_resetn,
  input  logic                   cfg_enable,
  input  logic                   cfg_loopback,
  input  logic                   clear_stats,
  input  logic [7:0]             pcspma_status,
  input  logic                   tx_resetdone,
  input  logic                   rx_resetdone,
  input  logic                   tx_fault,
  output logic [79:0]            mac_tx_configuration_vector,
  output logic [79:0]            mac_rx_configuration_vector,
  output logic [535:0]           pcs_pma_configuration_vector,
  output logic                   link_up,
  output logic                   tx_gate,
  output logic [2:0]             link_state,
  output logic [C_CNT_WIDTH-1:0] flap_count,
  output logic [C_CNT_WIDTH-1:0] retry_count
);

  typedef enum logic [2:0] {
    ST_DISABLED  = 3'd0,
    ST_RESET     = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_WAIT_LOCK = 3'd3,
    ST_QUALIFY   = 3'd4,
    ST_UP        = 3'd5,
    ST_FAULT     = 3'd6
  } state_t;

  // Only one state uses the timeout, the reset pulse or a debounce at a time.
  // Every state change clears the counter, so one dwell counter serves all
  // three purposes.
  localparam int CW = $clog2(C_LOSS_TIMEOUT + C_DEBOUNCE_CYCLES + C_RESET_PULSE + 1);
  localparam logic [CW-1:0] RESET_LAST   = CW'(C_RESET_PULSE - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(C_LOSS_TIMEOUT - 1);
  localparam logic [CW-1:0] DEB_LAST     = CW'(C_DEBOUNCE_CYCLES - 1);
  localparam int N_SYNC = 4;

  // Reset is asserted asynchronously and released after two clean edges.
  logic [1:0] rst_sync_reg;
  logic       rst_n;

  always_ff @(posedge core_clk or negedge core_resetn) begin
    if (!core_resetn) rst_sync_reg <= 2'b00;
    else              rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign rst_n = rst_sync_reg[1];

  // Two-flop synchronisers for the foreign-domain status inputs.
  logic [N_SYNC-1:0] async_in;
  logic [N_SYNC-1:0] sync_vec;
  logic              unused_status;

  assign async_in      = {tx_fault, rx_resetdone, tx_resetdone, pcspma_status[0]};
  assign unused_status = ^pcspma_status[7:1];

  for (genvar gi = 0; gi < N_SYNC; gi++) begin : g_sync
    logic meta_reg;
    logic sync_reg;
    always_ff @(posedge core_clk or negedge rst_n) begin
      if (!rst_n) begin
        meta_reg <= 1'b0;
        sync_reg <= 1'b0;
      end else begin
        meta_reg <= async_in[gi];
        sync_reg <= meta_reg;
      end
    end
    assign sync_vec[gi] = sync_reg;
  end

  logic lock_s, done_s, fault_s;
  assign lock_s  = sync_vec[0];
  assign done_s  = sync_vec[1] & sync_vec[2];
  assign fault_s = sync_vec[3];

  state_t                 state_reg, state_next;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic                   flap_inc, retry_inc;
  logic [C_CNT_WIDTH-1:0] flap_reg, retry_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CW'(1);
    flap_inc   = 1'b0;
    retry_inc  = 1'b0;
    if (!cfg_enable) begin
      state_next = ST_DISABLED;
    end else if (fault_s && state_reg != ST_DISABLED) begin
      state_next = ST_FAULT;
      flap_inc   = (state_reg == ST_UP);
    end else begin
      case (state_reg)
        ST_DISABLED:  state_next = ST_RESET;
        ST_RESET:     if (cnt_reg == RESET_LAST) state_next = ST_WAIT_DONE;
        ST_WAIT_DONE: begin
          if (done_s) begin
            state_next = ST_WAIT_LOCK;
          end else if (cnt_reg == TIMEOUT_LAST) begin
            state_next = ST_RESET;
            retry_inc  = 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_next = ST_QUALIFY;
          end else if (cnt_reg == TIMEOUT_LAST) begin
            state_next = ST_RESET;
            retry_inc  = 1'b1;
          end
        end
        ST_QUALIFY: begin
          if (!lock_s)                   state_next = ST_WAIT_LOCK;
          else if (cnt_reg == DEB_LAST)  state_next = ST_UP;
        end
        ST_UP: begin
          if (!lock_s) begin
            state_next = ST_WAIT_LOCK;
            flap_inc   = 1'b1;
          end
        end
        // A fault still present holds FAULT through the priority branch
        // above, so this branch counts only fault-clear cycles.
        ST_FAULT:     if (cnt_reg == DEB_LAST) state_next = ST_RESET;
        default:      state_next = ST_DISABLED;
      endcase
    end
    // An active fault in FAULT keeps the state but restarts the clear debounce.
    if (state_next != state_reg || (state_reg == ST_FAULT && fault_s)) cnt_next = '0;
  end

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_DISABLED;
      cnt_reg   <= '0;
      flap_reg  <= '0;
      retry_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (clear_stats)                            flap_reg <= '0;
      else if (flap_inc && flap_reg != '1)        flap_reg <= flap_reg + 1'b1;
      if (clear_stats)                            retry_reg <= '0;
      else if (retry_inc && retry_reg != '1)      retry_reg <= retry_reg + 1'b1;
    end
  end

  // The outputs are registered from the registered state.
  logic       rst_out_reg, en_out_reg, loop_reg, up_reg;
  logic [2:0] state_out_reg;

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_out_reg   <= 1'b1;
      en_out_reg    <= 1'b0;
      loop_reg      <= 1'b0;
      up_reg        <= 1'b0;
      state_out_reg <= 3'd0;
    end else begin
      rst_out_reg   <= (state_reg == ST_DISABLED) || (state_reg == ST_RESET);
      en_out_reg    <= (state_reg == ST_WAIT_LOCK) || (state_reg == ST_QUALIFY) ||
                       (state_reg == ST_UP);
      loop_reg      <= cfg_loopback;
      up_reg        <= (state_reg == ST_UP);
      state_out_reg <= state_reg;
    end
  end

  assign mac_tx_configuration_vector  = {78'd0, en_out_reg, rst_out_reg};
  assign mac_rx_configuration_vector  = {78'd0, en_out_reg, rst_out_reg};
  assign pcs_pma_configuration_vector = {424'd0, rst_out_reg, 95'd0, rst_out_reg, 14'd0, loop_reg};
  assign link_up     = up_reg;
  assign tx_gate     = up_reg;
  assign link_state  = state_out_reg;
  assign flap_count  = flap_reg;
  assign retry_count = retry_reg;

endmodule
